// File: rtl/nw_edge_probe_pkg.sv
// nw_edge_probe_pkg
// Shared definitions for the north-edge capture probe:
//   - probe_state_e : capture FSM states
//   - WORD_W and field offsets of the 36-bit capture word
//     {N4END, N2END, N2MID, N1END}, N1END in the low nibble
//   - turn_idx()    : index reversal used by the southward turnaround
package nw_edge_probe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } probe_state_e;

  localparam int unsigned N1_W      = 4;
  localparam int unsigned N2_W      = 8;
  localparam int unsigned N4_W      = 16;
  localparam int unsigned WORD_W    = 36;
  localparam int unsigned OFF_N1    = 0;
  localparam int unsigned OFF_N2MID = 4;
  localparam int unsigned OFF_N2END = 12;
  localparam int unsigned OFF_N4    = 20;

  // Bit i of a southward wire group is driven by bit (width-1-i) of the
  // matching northward group.
  function automatic int unsigned turn_idx(input int unsigned width,
                                           input int unsigned idx);
    return width - 32'd1 - idx;
  endfunction

endpackage

// File: rtl/nw_edge_probe_fifo.sv
// nw_edge_probe_fifo
// Synchronous FIFO holding captured words.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clr          : synchronous pointer clear (start of a new capture)
//   push, din    : write request and data (caller must not push when full
//                  unless popping on the same edge)
//   pop          : read request; ignored while empty
//   head         : oldest entry, forced to zero while empty
//   full, empty  : occupancy flags
//   count        : number of stored entries
// Pointers are one bit wider than the address so full and empty can be
// told apart: equal pointers mean empty, equal address bits with differing
// MSBs mean full.
module nw_edge_probe_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_pop_s;

  assign empty    = (wr_ptr_r == rd_ptr_r);
  assign full     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count    = wr_ptr_r - rd_ptr_r;
  assign do_pop_s = pop && !empty;
  assign head     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; clear wins over any concurrent pop.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
    end
  end

  // Storage write; contents need no reset because head is gated by empty.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/nw_edge_probe.sv
// nw_edge_probe
// North-edge termination with a debug capture tap. Every north-going wire
// is returned southward with its index reversed; in parallel the bundle
// can be snapshotted into a FIFO on a trigger and read out over a
// valid/ready port.
// Ports:
//   UserCLK, RESET             : clock, synchronous active-high reset
//   N1END/N2MID/N2END/N4END    : north-going wire bundle (capture source)
//   S1BEG/S2BEG/S2BEGb/S4BEG   : index-reversed southward return wires
//   arm, trig_mode             : start capture; 0 = immediate, 1 = match
//   match_val, match_mask      : N4END compare value and participating bits
//   rd_valid, rd_ready, rd_data: FIFO readout {N4END,N2END,N2MID,N1END}
//   busy                       : capture armed or in progress
//   trig_delay                 : cycles spent waiting for trigger, saturating
// Build option:
//   NW_EDGE_PROBE_LOOPBACK_REG_EN - register the southward wires on UserCLK
//   (one cycle latency, reset to zero). Default: combinational wiring.
module nw_edge_probe
  import nw_edge_probe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic              UserCLK,
  input  logic              RESET,
  input  logic [3:0]        N1END,
  input  logic [7:0]        N2MID,
  input  logic [7:0]        N2END,
  input  logic [15:0]       N4END,
  output logic [3:0]        S1BEG,
  output logic [7:0]        S2BEG,
  output logic [7:0]        S2BEGb,
  output logic [15:0]       S4BEG,
  input  logic              arm,
  input  logic              trig_mode,
  input  logic [15:0]       match_val,
  input  logic [15:0]       match_mask,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [35:0]       rd_data,
  output logic              busy,
  output logic [CNT_W-1:0]  trig_delay
);

  localparam int unsigned       PW      = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0]     DEPTH_C = PW'(DEPTH);

  probe_state_e      state_r;
  probe_state_e      state_s;
  logic [PW-1:0]     cap_cnt_r;
  logic [PW-1:0]     cap_cnt_s;
  logic [CNT_W-1:0]  trig_delay_r;
  logic [CNT_W-1:0]  trig_delay_s;
  logic              push_s;
  logic              clr_s;
  logic              trig_s;
  logic [WORD_W-1:0] word_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_pop_s;
  logic              fifo_push_s;
  logic [PW-1:0]     fifo_count_s;

  logic [3:0]        s1_s;
  logic [7:0]        s2_s;
  logic [7:0]        s2b_s;
  logic [15:0]       s4_s;

  // ---------------------------------------------------------------------
  // Southward turnaround
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < N1_W; g++) begin : g_s1
    assign s1_s[g] = N1END[turn_idx(N1_W, g)];
  end
  for (genvar g = 0; g < N2_W; g++) begin : g_s2
    assign s2_s[g]  = N2MID[turn_idx(N2_W, g)];
    assign s2b_s[g] = N2END[turn_idx(N2_W, g)];
  end
  for (genvar g = 0; g < N4_W; g++) begin : g_s4
    assign s4_s[g] = N4END[turn_idx(N4_W, g)];
  end

`ifdef NW_EDGE_PROBE_LOOPBACK_REG_EN
  // Registered southward return wires.
  always_ff @(posedge UserCLK) begin
    if (RESET) begin
      S1BEG  <= 4'h0;
      S2BEG  <= 8'h00;
      S2BEGb <= 8'h00;
      S4BEG  <= 16'h0000;
    end else begin
      S1BEG  <= s1_s;
      S2BEG  <= s2_s;
      S2BEGb <= s2b_s;
      S4BEG  <= s4_s;
    end
  end
`else
  assign S1BEG  = s1_s;
  assign S2BEG  = s2_s;
  assign S2BEGb = s2b_s;
  assign S4BEG  = s4_s;
`endif

  // ---------------------------------------------------------------------
  // Capture word and trigger
  // ---------------------------------------------------------------------
  assign word_s[OFF_N1    +: N1_W] = N1END;
  assign word_s[OFF_N2MID +: N2_W] = N2MID;
  assign word_s[OFF_N2END +: N2_W] = N2END;
  assign word_s[OFF_N4    +: N4_W] = N4END;

  // A zero mask makes the compare trivially true.
  assign trig_s = !trig_mode ||
                  ((N4END & match_mask) == (match_val & match_mask));

  assign fifo_pop_s  = rd_ready && !fifo_empty_s;
  assign fifo_push_s = push_s && (!fifo_full_s || fifo_pop_s);

  // ---------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------
  // Next-state, write strobe, capture count and trigger-delay update.
  always_comb begin
    state_s      = state_r;
    cap_cnt_s    = cap_cnt_r;
    trig_delay_s = trig_delay_r;
    push_s       = 1'b0;
    clr_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (arm) begin
          state_s      = ST_ARMED;
          clr_s        = 1'b1;
          cap_cnt_s    = {PW{1'b0}};
          trig_delay_s = {CNT_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (trig_s) begin
          push_s    = 1'b1;
          cap_cnt_s = cap_cnt_r + PW'(1'b1);
          // cap_cnt_r is zero here, so this only ends a one-word capture.
          if (cap_cnt_s == DEPTH_C) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_CAPTURE;
          end
        end else if (trig_delay_r != {CNT_W{1'b1}}) begin
          trig_delay_s = trig_delay_r + CNT_W'(1'b1);
        end else begin
          trig_delay_s = trig_delay_r;
        end
      end
      ST_CAPTURE: begin
        push_s    = 1'b1;
        cap_cnt_s = cap_cnt_r + PW'(1'b1);
        if (cap_cnt_s == DEPTH_C) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        // Leave once the FIFO is drained: already empty, or last pop now.
        if (fifo_empty_s) begin
          state_s = ST_IDLE;
        end else if (fifo_pop_s && (fifo_count_s == PW'(1'b1))) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge UserCLK) begin
    if (RESET) begin
      state_r      <= ST_IDLE;
      cap_cnt_r    <= {PW{1'b0}};
      trig_delay_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_s;
      cap_cnt_r    <= cap_cnt_s;
      trig_delay_r <= trig_delay_s;
    end
  end

  nw_edge_probe_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (UserCLK),
    .rst   (RESET),
    .clr   (clr_s),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (word_s),
    .head  (rd_data),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign rd_valid   = !fifo_empty_s;
  assign busy       = (state_r == ST_ARMED) || (state_r == ST_CAPTURE);
  assign trig_delay = trig_delay_r;

endmodule

// File: tb/tb_nw_edge_probe.sv
// tb_nw_edge_probe
// Self-checking bench for nw_edge_probe: directed scenarios followed by
// randomized traffic, all compared against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_nw_edge_probe;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic              UserCLK = 1'b0;
  logic              RESET;
  logic [3:0]        N1END;
  logic [7:0]        N2MID;
  logic [7:0]        N2END;
  logic [15:0]       N4END;
  logic [3:0]        S1BEG;
  logic [7:0]        S2BEG;
  logic [7:0]        S2BEGb;
  logic [15:0]       S4BEG;
  logic              arm;
  logic              trig_mode;
  logic [15:0]       match_val;
  logic [15:0]       match_mask;
  logic              rd_valid;
  logic              rd_ready;
  logic [35:0]       rd_data;
  logic              busy;
  logic [CNT_W-1:0]  trig_delay;

  always #5 UserCLK = ~UserCLK;

  nw_edge_probe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .UserCLK    (UserCLK),
    .RESET      (RESET),
    .N1END      (N1END),
    .N2MID      (N2MID),
    .N2END      (N2END),
    .N4END      (N4END),
    .S1BEG      (S1BEG),
    .S2BEG      (S2BEG),
    .S2BEGb     (S2BEGb),
    .S4BEG      (S4BEG),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .match_val  (match_val),
    .match_mask (match_mask),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .busy       (busy),
    .trig_delay (trig_delay)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: capture phase, queue of stored words, delay count
  // ------------------------------------------------------------------
  typedef enum int {PH_IDLE, PH_ARMED, PH_CAPTURE, PH_DONE} phase_e;
  phase_e      m_phase   = PH_IDLE;
  logic [35:0] exp_q[$];
  int          m_written = 0;
  int          m_dly     = 0;
  logic [3:0]  m_s1;
  logic [7:0]  m_s2, m_s2b;
  logic [15:0] m_s4;
  bit          lb_known  = 1'b0;

  function automatic logic [3:0] rev4(input logic [3:0] v);
    logic [3:0] r;
    r = {<<{v}};
    return r;
  endfunction
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    r = {<<{v}};
    return r;
  endfunction
  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    r = {<<{v}};
    return r;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    int          sz  = exp_q.size();
    bit          pop = (sz != 0) && rd_ready;
    bit          hit;
    logic [35:0] w   = {N4END, N2END, N2MID, N1END};
    if (RESET) begin
      m_s1 = 4'h0; m_s2 = 8'h00; m_s2b = 8'h00; m_s4 = 16'h0000;
    end else begin
      m_s1 = rev4(N1END); m_s2 = rev8(N2MID); m_s2b = rev8(N2END); m_s4 = rev16(N4END);
    end
    lb_known = 1'b1;
    if (RESET) begin
      exp_q.delete();
      m_phase   = PH_IDLE;
      m_dly     = 0;
      m_written = 0;
      return;
    end
    if (pop) void'(exp_q.pop_front());
    hit = !trig_mode || ((N4END & match_mask) == (match_val & match_mask));
    case (m_phase)
      PH_IDLE: if (arm) begin
        exp_q.delete();
        m_dly = 0; m_written = 0; m_phase = PH_ARMED;
      end
      PH_ARMED: if (hit) begin
        exp_q.push_back(w);
        m_written = 1;
        m_phase = (m_written == DEPTH) ? PH_DONE : PH_CAPTURE;
      end else if (m_dly < (1 << CNT_W) - 1) begin
        m_dly++;
      end
      PH_CAPTURE: begin
        exp_q.push_back(w);
        m_written++;
        if (m_written == DEPTH) m_phase = PH_DONE;
      end
      PH_DONE: if (sz == 0 || (pop && sz == 1)) m_phase = PH_IDLE;
      default: m_phase = PH_IDLE;
    endcase
  endtask

  task automatic check_lb();
`ifdef NW_EDGE_PROBE_LOOPBACK_REG_EN
    if (lb_known) begin
      check_val("S1BEG", 64'(S1BEG), 64'(m_s1));
      check_val("S2BEG", 64'(S2BEG), 64'(m_s2));
      check_val("S2BEGb", 64'(S2BEGb), 64'(m_s2b));
      check_val("S4BEG", 64'(S4BEG), 64'(m_s4));
    end
`else
    check_val("S1BEG", 64'(S1BEG), 64'(rev4(N1END)));
    check_val("S2BEG", 64'(S2BEG), 64'(rev8(N2MID)));
    check_val("S2BEGb", 64'(S2BEGb), 64'(rev8(N2END)));
    check_val("S4BEG", 64'(S4BEG), 64'(rev16(N4END)));
`endif
  endtask

  task automatic compare_all();
    logic [35:0] exp_head;
    exp_head = (exp_q.size() != 0) ? exp_q[0] : 36'h0;
    check_val("rd_valid", 64'(rd_valid), 64'(exp_q.size() != 0));
    check_val("rd_data", 64'(rd_data), 64'(exp_head));
    check_val("busy", 64'(busy), 64'(m_phase == PH_ARMED || m_phase == PH_CAPTURE));
    check_val("trig_delay", 64'(trig_delay), 64'(m_dly));
    check_lb();
  endtask

  // One clock: inputs were set after the previous falling edge.
  task automatic tick();
    #1;
    check_lb();
    model_edge();
    @(posedge UserCLK);
    #1;
    compare_all();
    @(negedge UserCLK);
  endtask

  task automatic drain();
    rd_ready = 1'b1;
    for (int k = 0; k < 2 * DEPTH + 4 && rd_valid; k++) tick();
    check_val("drain_empty", 64'(rd_valid), 64'(1'b0));
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] got_q[$];
    int         pops;
    RESET = 1'b1; arm = 1'b0; trig_mode = 1'b0; rd_ready = 1'b0;
    match_val = 16'h0000; match_mask = 16'h0000;
    N1END = 4'h5; N2MID = 8'h3C; N2END = 8'h81; N4END = 16'hBEEF;
    @(negedge UserCLK);

    // Reset then idle
    tick(); tick();
    check_val("rst_rd_valid", 64'(rd_valid), 64'(1'b0));
    check_val("rst_busy", 64'(busy), 64'(1'b0));
    check_val("rst_trig_delay", 64'(trig_delay), 64'(16'h0));
    RESET = 1'b0;
    N4END = 16'h0001; N1END = 4'b0011;
    tick();
    check_val("lb_s4_8000", 64'(S4BEG), 64'(16'h8000));
    check_val("lb_s1_1100", 64'(S1BEG), 64'(4'b1100));

    // Immediate trigger, four words with N1END 0..3
    trig_mode = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      N1END = 4'(k);
      tick();
    end
    check_val("imm_busy_low", 64'(busy), 64'(1'b0));
    check_val("imm_trig_delay", 64'(trig_delay), 64'(16'h0));
    for (int k = 0; k < DEPTH; k++) begin
      check_val("imm_n1_field", 64'(rd_data[3:0]), 64'(k));
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    tick();

    // Pattern trigger after ten non-matching cycles
    trig_mode = 1'b1; match_mask = 16'h00FF; match_val = 16'h00A5; arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 10; k++) begin
      N4END = {8'($urandom), 8'h5A};
      tick();
    end
    N4END = 16'h3CA5;
    tick();
    check_val("pat_trig_delay", 64'(trig_delay), 64'(16'd10));
    check_val("pat_first_n4", 64'(rd_data[35:20]), 64'(16'h3CA5));
    for (int k = 0; k < DEPTH - 1; k++) tick();
    drain();

    // Readout concurrent with capture
    trig_mode = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0; rd_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      N1END = 4'(4 + k);
      if (rd_valid) got_q.push_back(rd_data[3:0]);
      tick();
    end
    for (int k = 0; k < 10 && rd_valid; k++) begin
      got_q.push_back(rd_data[3:0]);
      tick();
    end
    check_val("stream_count", 64'(got_q.size()), 64'(DEPTH));
    for (int k = 0; k < got_q.size(); k++)
      check_val("stream_order", 64'(got_q[k]), 64'(4 + k));
    rd_ready = 1'b0; arm = 1'b1;
    tick();
    check_val("stream_back_idle", 64'(busy), 64'(1'b1));
    arm = 1'b0;
    for (int k = 0; k < DEPTH; k++) tick();
    drain();

    // arm during CAPTURE ignored
    trig_mode = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0; tick();
    arm = 1'b1; tick();
    arm = 1'b0; tick(); tick();
    check_val("rearm_trig_delay", 64'(trig_delay), 64'(16'h0));
    pops = 0;
    rd_ready = 1'b1;
    for (int k = 0; k < 10 && rd_valid; k++) begin
      pops++;
      tick();
    end
    check_val("rearm_words", 64'(pops), 64'(DEPTH));
    rd_ready = 1'b0;
    tick();

    // RESET mid-capture
    arm = 1'b1; tick();
    arm = 1'b0; tick(); tick();
    RESET = 1'b1; tick();
    RESET = 1'b0;
    check_val("midrst_rd_valid", 64'(rd_valid), 64'(1'b0));
    check_val("midrst_busy", 64'(busy), 64'(1'b0));

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      N1END = 4'($urandom);
      N2MID = 8'($urandom);
      N2END = 8'($urandom);
      N4END = 16'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        trig_mode = 1'($urandom);
        case ($urandom_range(0, 2))
          0:       match_mask = 16'h0000;
          1:       match_mask = 16'h000F;
          default: match_mask = 16'($urandom);
        endcase
        match_val = 16'($urandom);
      end
      if ($urandom_range(0, 3) == 0)
        N4END = (N4END & ~match_mask) | (match_val & match_mask);
      arm      = ($urandom_range(0, 7) == 0);
      rd_ready = 1'($urandom);
      RESET    = ($urandom_range(0, 99) == 0);
      tick();
    end
    RESET = 1'b0; arm = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nw_edge_probe.md
# nw_edge_probe

North-edge capture stage that sits directly on the north-going wire bundle (N1END, N2MID, N2END, N4END) at the fabric's top-left boundary and takes over the termination role there. It returns every wire southward with the index-reversed turnaround mapping, so fabric routing is unchanged. It also snapshots the bundle into a small FIFO when a trigger fires and streams the snapshots out over a valid/ready port for debug readout.

## Interface
- DEPTH, 4, FIFO entries and words captured per trigger; power of two, 2..16
- CNT_W, 16, width of trigger-delay counter
- UserCLK  in  1  fabric user clock, sole clock
- RESET  in  1  synchronous, active-high reset
- N1END  in  4  north single wires
- N2MID  in  8  north double wires, mid tap
- N2END  in  8  north double wires, end tap
- N4END  in  16  north quad wires
- S1BEG  out  4  S1BEG[i] = N1END[3-i]
- S2BEG  out  8  S2BEG[i] = N2MID[7-i]
- S2BEGb  out  8  S2BEGb[i] = N2END[7-i]
- S4BEG  out  16  S4BEG[i] = N4END[15-i]
- arm  in  1  start a capture; honoured only in IDLE
- trig_mode  in  1  0 = trigger immediately, 1 = trigger on pattern match
- match_val  in  16  compare value for N4END
- match_mask  in  16  1 = bit participates in compare
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  consumer accepts rd_data
- rd_data  out  36  FIFO head, {N4END, N2END, N2MID, N1END}, N1END in [3:0]
- busy  out  1  state is ARMED or CAPTURE
- trig_delay  out  CNT_W  cycles from arm acceptance to trigger, saturating

## Operation
- Capture word = {N4END, N2END, N2MID, N1END}, sampled at the UserCLK edge.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE: arm=1 -> ARMED. FIFO pointers are cleared and trig_delay is set to 0 on the same edge.
- ARMED: the trigger is true if trig_mode=0, or if (N4END & match_mask) == (match_val & match_mask).
  - Trigger true: write the word, capture count = 1, -> CAPTURE. If DEPTH words are already written, go to DONE instead.
  - Trigger false: trig_delay increments, saturating at all-ones.
- CAPTURE: write one word every cycle. -> DONE on the edge that writes word DEPTH.
- DONE: no writes. -> IDLE on the edge that pops the last entry, or immediately if the FIFO is already empty.
- mask = 0 with trig_mode = 1: trigger matches on the first ARMED cycle.
- Readout is allowed in any state. A pop happens on rd_valid & rd_ready.
- Simultaneous pop and write: both take effect. Occupancy is unchanged and the FIFO cannot overflow, because it is cleared at arm and receives at most DEPTH writes per capture.
- rd_ready while empty: ignored.
- arm outside IDLE: ignored. It does not restart and does not clear.
- Pointers are log2(DEPTH)+1 bits with natural wrap. Full = MSBs differ and LSBs equal. Empty = pointers equal.

## Timing
- Reset values: state IDLE, pointers 0, rd_valid 0, busy 0, trig_delay 0. rd_data is 0 while empty; storage contents are don't-care.
- RESET mid-capture aborts on that edge. Pending data is discarded.
- Loopback outputs are purely combinational, with zero latency.
- Trigger-to-first-word: the word sampled on the trigger edge is visible on rd_data/rd_valid one cycle later.
- busy rises the cycle after arm acceptance. It falls the cycle after the edge that writes word DEPTH.
- rd_data and rd_valid come combinationally from registered state. There is no combinational path from rd_ready to rd_valid or rd_data.

## Configuration
- NW_EDGE_PROBE_LOOPBACK_REG_EN
  - Defined: S1BEG, S2BEG, S2BEGb and S4BEG are registered on UserCLK (one cycle of latency, reset to 0). Capture sampling is unaffected.
  - Undefined: loopback is combinational wiring, identical in mapping to a passive terminator.

## Structure
- Shared package nw_edge_probe_pkg holds:
  - state enum (IDLE, ARMED, CAPTURE, DONE)
  - word-width constant 36 and field offsets (N1 0, N2MID 4, N2END 12, N4 20)
  - function for the turnaround index reversal
- One sub-module: nw_edge_probe_fifo, a synchronous FIFO parameterised by DEPTH and width, with push, pop, full, empty and head outputs.
- FSM, trigger compare, counters and loopback live in the top module.

## Test plan
- Reset then idle; drive N4END=16'h0001 -> S4BEG=16'h8000; N1END=4'b0011 -> S1BEG=4'b1100; rd_valid=0, busy=0.
- trig_mode=0, arm pulse, N1END incrementing 0,1,2,3 with rd_ready=0 -> four words with N1END fields 0..3 in order; busy drops after the 4th write; trig_delay=0.
- trig_mode=1, mask=16'h00FF, val=16'h00A5; drive non-matching N4END for 10 cycles, then N4END=16'h3CA5 -> trig_delay=10; first word has N4END field 16'h3CA5.
- rd_ready=1 held during CAPTURE -> every word popped exactly once, no loss, in order; the edge that pops the last word returns state to IDLE.
- arm pulse during CAPTURE -> ignored: capture completes with DEPTH words and trig_delay is unchanged. RESET asserted mid-CAPTURE -> next cycle rd_valid=0, busy=0.
- With NW_EDGE_PROBE_LOOPBACK_REG_EN: N2END step at cycle t -> S2BEGb reflects it at t+1; reset value 0.
